// File: rtl/alu_core_if.sv
// alu_core_if: request/response bundle for alu_core.
//   master (driver side): start_i, op_i, a_i, b_i, out_en_i  ->  DUT
//   slave  (alu_core)   : bus_o, busy_o, done_o, c_o, z_o, n_o, v_o  ->  driver
// Signal names keep the _i/_o suffix from the core's point of view.
interface alu_core_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_en_i;
  logic [WIDTH-1:0] bus_o;
  logic             busy_o;
  logic             done_o;
  logic             c_o;
  logic             z_o;
  logic             n_o;
  logic             v_o;

  modport master (
    output start_i, op_i, a_i, b_i, out_en_i,
    input  bus_o, busy_o, done_o, c_o, z_o, n_o, v_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, out_en_i,
    output bus_o, busy_o, done_o, c_o, z_o, n_o, v_o
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: small ALU with single-cycle logic/arithmetic ops and a multi-cycle
// unsigned shift-add multiplier.
//   clk_i  : clock, all state changes on rising edge
//   rst_i  : synchronous, active-high reset
//   alu_io : alu_core_if.slave
//     start_i/op_i/a_i/b_i : request, sampled only while busy_o=0
//     out_en_i             : gates result onto bus_o (combinational)
//     bus_o                : result when out_en_i=1, else zero
//     busy_o               : high while a MUL is in progress
//     done_o               : one-cycle pulse when result/flags update
//     c_o/z_o/n_o/v_o      : registered carry/zero/negative/overflow flags
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 CMP, 110 MUL, 111 NOTA.
module alu_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  alu_core_if.slave   alu_io
);

  localparam int unsigned Msb  = WIDTH - 1;
  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAnd  = 3'b010;
  localparam logic [2:0] OpOr   = 3'b011;
  localparam logic [2:0] OpXor  = 3'b100;
  localparam logic [2:0] OpCmp  = 3'b101;
  localparam logic [2:0] OpMul  = 3'b110;
  localparam logic [2:0] OpNota = 3'b111;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               c_q, z_q, n_q, v_q;
  logic               busy_q, done_q;
  logic [2*WIDTH-1:0] acc_q;     // product accumulator
  logic [2*WIDTH-1:0] mcand_q;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_q;  // multiplier, shifted right each step
  logic [CntW-1:0]    cnt_q;

  // Single-cycle ALU datapath
  logic [WIDTH:0]     sum_ext, diff_ext;
  logic [WIDTH-1:0]   alu_res;   // value written to result_q
  logic [WIDTH-1:0]   flag_src;  // value Z/N are derived from (differs for CMP)
  logic               alu_c, alu_v;

  always_comb begin
    sum_ext  = {1'b0, alu_io.a_i} + {1'b0, alu_io.b_i};
    // Top bit of the extended difference is the borrow (a < b unsigned).
    diff_ext = {1'b0, alu_io.a_i} - {1'b0, alu_io.b_i};
    alu_res  = result_q;
    flag_src = result_q;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    unique case (alu_io.op_i)
      OpAdd: begin
        alu_res  = sum_ext[WIDTH-1:0];
        flag_src = sum_ext[WIDTH-1:0];
        alu_c    = sum_ext[WIDTH];
        alu_v    = (alu_io.a_i[Msb] == alu_io.b_i[Msb]) &&
                   (sum_ext[Msb] != alu_io.a_i[Msb]);
      end
      OpSub, OpCmp: begin
        // CMP keeps result_q (default) and only takes the flags.
        if (alu_io.op_i == OpSub) alu_res = diff_ext[WIDTH-1:0];
        flag_src = diff_ext[WIDTH-1:0];
        alu_c    = diff_ext[WIDTH];
        alu_v    = (alu_io.a_i[Msb] != alu_io.b_i[Msb]) &&
                   (diff_ext[Msb] != alu_io.a_i[Msb]);
      end
      OpAnd: begin
        alu_res  = alu_io.a_i & alu_io.b_i;
        flag_src = alu_res;
      end
      OpOr: begin
        alu_res  = alu_io.a_i | alu_io.b_i;
        flag_src = alu_res;
      end
      OpXor: begin
        alu_res  = alu_io.a_i ^ alu_io.b_i;
        flag_src = alu_res;
      end
      OpNota: begin
        alu_res  = ~alu_io.a_i;
        flag_src = alu_res;
      end
      OpMul: begin
        // Handled by the multi-cycle path; defaults are unused.
      end
      default: begin
      end
    endcase
  end

  // Multiplier step: add the shifted multiplicand when the current bit is set.
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   prod_lo, prod_hi;

  always_comb begin
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod_lo  = acc_next[WIDTH-1:0];
    prod_hi  = acc_next[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (alu_io.start_i) begin
            if (alu_io.op_i == OpMul) begin
              mcand_q  <= {{WIDTH{1'b0}}, alu_io.a_i};
              mplier_q <= alu_io.b_i;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= StMul;
            end else begin
              result_q <= alu_res;
              c_q      <= alu_c;
              v_q      <= alu_v;
              z_q      <= (flag_src == '0);
              n_q      <= flag_src[Msb];
              done_q   <= 1'b1;
            end
          end
        end
        StMul: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            // Last multiplier bit: commit the truncated product this edge.
            result_q <= prod_lo;
            c_q      <= |prod_hi;
            v_q      <= |prod_hi;
            z_q      <= (prod_lo == '0);
            n_q      <= prod_lo[Msb];
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_io.bus_o  = alu_io.out_en_i ? result_q : '0;
  assign alu_io.busy_o = busy_q;
  assign alu_io.done_o = done_q;
  assign alu_io.c_o    = c_q;
  assign alu_io.z_o    = z_q;
  assign alu_io.n_o    = n_q;
  assign alu_io.v_o    = v_q;

endmodule
